// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state type, defaults and timing helper for the systolic run sequencer
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    DRAIN,
    CAPTURE,
    DONE
  } seq_state_t;

  localparam int MATRIX_SIZE_DEF = 4;
  localparam int BRAM_DEPTH_DEF  = 2;

  // Wavefront skew across the array plus pipeline slack before outputs settle.
  function automatic int drain_cycles(input int matrix_size);
    return 2 * matrix_size + 2;
  endfunction

endpackage

// File: rtl/seq_delay.sv
// rtl/seq_delay.sv - 1-bit shift register that aligns control with BRAM read latency
module seq_delay #(
  parameter int LEN = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [LEN-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset) sr <= '0;
    else       sr <= (sr << 1) | LEN'(d);
  end

  assign q = sr[LEN-1];

endmodule

// File: rtl/systolic_sequencer.sv
// rtl/systolic_sequencer.sv - run-level pass sequencer for the 4x4 systolic matmul datapath
// Optional busy-cycle counter built only when SYSTOLIC_SEQ_PERF_CNT_EN is defined.
module systolic_sequencer
  import systolic_pkg::*;
#(
  parameter int MATRIX_SIZE  = MATRIX_SIZE_DEF,
  parameter int BRAM_DEPTH   = BRAM_DEPTH_DEF,
  parameter int BRAM_LATENCY = 1,
  parameter int DRAIN_CYCLES = drain_cycles(MATRIX_SIZE),
  parameter int TILE_W       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [TILE_W-1:0]     tile_count,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_en,
  output logic [BRAM_DEPTH-1:0] address,
  output logic                  acc_clear,
  output logic                  enable_cu,
  output logic                  capture,
  output logic [TILE_W-1:0]     tiles_left,
  output logic [31:0]           cycle_count
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + MATRIX_SIZE + 1);

  seq_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BRAM_DEPTH-1:0] idx_q, idx_d;
  logic [BRAM_DEPTH-1:0] addr_d;
  logic [TILE_W-1:0]     tiles_d;
  logic                  fetch_or_drain;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    addr_d  = address;
    tiles_d = tiles_left;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (tile_count != '0) begin
            state_d = CLEAR;
            tiles_d = tile_count;
            idx_d   = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      CLEAR: begin
        state_d = FETCH;
        cnt_d   = '0;
        addr_d  = BRAM_DEPTH'(idx_q * MATRIX_SIZE);
      end
      FETCH: begin
        if (cnt_q == CNT_W'(MATRIX_SIZE - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          addr_d = address + BRAM_DEPTH'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) state_d = CAPTURE;
        else                                   cnt_d   = cnt_q + CNT_W'(1);
      end
      CAPTURE: begin
        tiles_d = tiles_left - TILE_W'(1);
        idx_d   = idx_q + BRAM_DEPTH'(1);
        state_d = (tiles_left > TILE_W'(1)) ? CLEAR : DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      addr_d  = '0;
      tiles_d = '0;
    end
  end

  // Outputs are flops loaded from the next state so they change with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      address    <= '0;
      tiles_left <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bram_en    <= 1'b0;
      acc_clear  <= 1'b0;
      capture    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      address    <= addr_d;
      tiles_left <= tiles_d;
      busy       <= state_d inside {CLEAR, FETCH, DRAIN, CAPTURE};
      done       <= (state_d == DONE);
      bram_en    <= (state_d == FETCH);
      acc_clear  <= (state_d == CLEAR);
      capture    <= (state_d == CAPTURE);
    end
  end

  assign fetch_or_drain = (state_q == FETCH) || (state_q == DRAIN);

  seq_delay #(
    .LEN(BRAM_LATENCY)
  ) u_cu_delay (
    .clk  (clk),
    .reset(reset || abort),
    .d    (fetch_or_drain),
    .q    (enable_cu)
  );

`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
  logic start_ok;
  assign start_ok = (state_q == IDLE) && start && !abort;

  always_ff @(posedge clk) begin
    if (reset)                           cycle_count <= '0;
    else if (start_ok)                   cycle_count <= '0;
    else if (busy && cycle_count != '1)  cycle_count <= cycle_count + 32'd1;
  end
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_systolic_sequencer.sv
// tb/tb_systolic_sequencer.sv - self-checking bench for systolic_sequencer
module tb_systolic_sequencer;

  localparam int MS       = 4;
  localparam int BD       = 2;
  localparam int TW       = 8;
  localparam int PASS_LEN = 1 + MS + (2 * MS + 2) + 1;
`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [TW-1:0] tile_count;
  logic          busy, done, bram_en, acc_clear, enable_cu, capture;
  logic [BD-1:0] address;
  logic [TW-1:0] tiles_left;
  logic [31:0]   cycle_count;

  always #5 clk = ~clk;

  systolic_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .tile_count (tile_count),
    .busy       (busy),
    .done       (done),
    .bram_en    (bram_en),
    .address    (address),
    .acc_clear  (acc_clear),
    .enable_cu  (enable_cu),
    .capture    (capture),
    .tiles_left (tiles_left),
    .cycle_count(cycle_count)
  );

  int checks = 0;
  int errors = 0;
  int gcyc   = 0;

  // Reference model: a run is just (start cycle, pass count); outputs follow from arithmetic.
  bit m_active;
  int m_t0, m_n, m_idle_addr, m_cc;

  typedef struct {
    bit busy, done, bram_en, acc_clear, enable_cu, capture;
    int address, tiles_left, cc;
  } exp_t;

  function automatic int addr_of(input int p, input int k);
    return (p * MS + k) % (1 << BD);
  endfunction

  function automatic exp_t model_out(input int c);
    exp_t e;
    int r, p, ph;
    e = '{default: 0};
    e.address = m_idle_addr;
    e.cc = PERF ? m_cc : 0;
    if (!m_active) return e;
    r = c - m_t0;
    if (r == PASS_LEN * m_n + 1) begin
      e.done = 1'b1;
      e.address = (m_n == 0) ? m_idle_addr : addr_of(m_n - 1, MS - 1);
      return e;
    end
    p  = (r - 1) / PASS_LEN;
    ph = (r - 1) % PASS_LEN;
    e.busy       = 1'b1;
    e.tiles_left = m_n - p;
    e.acc_clear  = (ph == 0);
    e.bram_en    = (ph >= 1 && ph <= MS);
    e.capture    = (ph == PASS_LEN - 1);
    e.enable_cu  = (ph >= 2);
    if (ph == 0)       e.address = (p == 0) ? m_idle_addr : addr_of(p - 1, MS - 1);
    else if (ph <= MS) e.address = addr_of(p, ph - 1);
    else               e.address = addr_of(p, MS - 1);
    return e;
  endfunction

  task automatic model_update(input int c, input bit s, input bit a, input bit r, input int tc);
    exp_t e;
    e = model_out(c);
    if (r) begin
      m_active = 0; m_idle_addr = 0; m_cc = 0;
    end else if (a && m_active) begin
      if (e.busy) m_cc++;
      m_active = 0; m_idle_addr = 0;
    end else if (m_active) begin
      if (e.busy) m_cc++;
      if (c - m_t0 >= PASS_LEN * m_n + 1) begin
        m_active = 0;
        if (m_n > 0) m_idle_addr = addr_of(m_n - 1, MS - 1);
      end
    end else if (s && !a) begin
      m_active = 1; m_t0 = c; m_n = tc; m_cc = 0;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, gcyc, act, exp);
    end
  endtask

  // Event trackers on actual DUT outputs, relative to the current scenario start.
  int base, done_at, n_done, n_capt, n_fetch, n_clear, n_busy;
  int capt_q[$];
  logic [TW-1:0] tl_hist [0:127];

  task automatic track_reset();
    base = gcyc; done_at = -1; n_done = 0; n_capt = 0;
    n_fetch = 0; n_clear = 0; n_busy = 0;
    capt_q.delete();
  endtask

  task automatic step(input bit s, input bit a, input bit r, input logic [TW-1:0] tc);
    exp_t e;
    int rel;
    rel = gcyc - base;
    if (done === 1'b1) begin n_done++; if (done_at < 0) done_at = rel; end
    if (capture === 1'b1) begin n_capt++; capt_q.push_back(rel); end
    if (bram_en === 1'b1)   n_fetch++;
    if (acc_clear === 1'b1) n_clear++;
    if (busy === 1'b1)      n_busy++;
    if (rel >= 0 && rel < 128) tl_hist[rel] = tiles_left;
    e = model_out(gcyc);
    chk("busy", busy, e.busy);
    chk("done", done, e.done);
    chk("bram_en", bram_en, e.bram_en);
    chk("acc_clear", acc_clear, e.acc_clear);
    chk("enable_cu", enable_cu, e.enable_cu);
    chk("capture", capture, e.capture);
    chk("address", address, e.address);
    chk("tiles_left", tiles_left, e.tiles_left);
    chk("cycle_count", cycle_count, e.cc);
    start = s; abort = a; reset = r; tile_count = tc;
    model_update(gcyc, s, a, r, int'(tc));
    @(posedge clk);
    @(negedge clk);
    gcyc++;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0);
  endtask

  typedef struct {
    logic [TW-1:0] tc;
    int done_at, captures, fetches, clears, busy_cycles;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'd1, 17, 1, 4, 1, 16};
    vecs[1] = '{8'd3, 49, 3, 12, 3, 48};
    vecs[2] = '{8'd0, 1, 0, 0, 0, 0};
    vecs[3] = '{8'd2, 33, 2, 8, 2, 32};
    vecs[4] = '{8'd5, 81, 5, 20, 5, 80};

    start = 0; abort = 0; reset = 1; tile_count = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    m_active = 0; m_idle_addr = 0; m_cc = 0;
    track_reset();
    idle_steps(2);

    foreach (vecs[v]) begin
      track_reset();
      step(1, 0, 0, vecs[v].tc);
      idle_steps(vecs[v].done_at + 2);
      chk("tbl_done_at", done_at, vecs[v].done_at);
      chk("tbl_n_done", n_done, 1);
      chk("tbl_captures", n_capt, vecs[v].captures);
      chk("tbl_fetches", n_fetch, vecs[v].fetches);
      chk("tbl_clears", n_clear, vecs[v].clears);
      chk("tbl_busy", n_busy, vecs[v].busy_cycles);
      for (int i = 0; i < capt_q.size(); i++) chk("tbl_capture_at", capt_q[i], PASS_LEN * (i + 1));
      chk("tbl_cycle_count", cycle_count, PERF ? PASS_LEN * vecs[v].tc : 0);
      if (vecs[v].tc == 8'd3) begin
        chk("tiles_at_1", tl_hist[1], 3);
        chk("tiles_at_17", tl_hist[17], 2);
        chk("tiles_at_33", tl_hist[33], 1);
        chk("tiles_at_49", tl_hist[49], 0);
      end
    end

    // Abort in DRAIN, then restart.
    track_reset();
    step(1, 0, 0, 8'd1);
    idle_steps(7);
    step(0, 1, 0, '0);
    chk("abort_busy", busy, 0);
    chk("abort_enable_cu", enable_cu, 0);
    chk("abort_address", address, 0);
    idle_steps(1);
    step(1, 0, 0, 8'd1);
    idle_steps(20);
    chk("abort_n_done", n_done, 1);
    chk("abort_done_at", done_at, 27);
    chk("abort_capture_at", capt_q.size() > 0 ? capt_q[0] : -1, 26);

    // Start ignored mid-run and during DONE; earliest restart the cycle after done.
    track_reset();
    step(1, 0, 0, 8'd1);
    idle_steps(4);
    step(1, 0, 0, 8'd5);
    idle_steps(11);
    step(1, 0, 0, 8'd2);
    step(1, 0, 0, 8'd1);
    idle_steps(21);
    chk("ign_n_capt", n_capt, 2);
    chk("ign_capture2_at", capt_q.size() > 1 ? capt_q[1] : -1, 34);
    chk("ign_tiles_at_6", tl_hist[6], 1);
    chk("ign_tiles_at_19", tl_hist[19], 1);

    // Reset mid-run.
    track_reset();
    step(1, 0, 0, 8'd2);
    idle_steps(3);
    step(0, 0, 1, '0);
    chk("rst_busy", busy, 0);
    chk("rst_bram_en", bram_en, 0);
    chk("rst_tiles_left", tiles_left, 0);
    chk("rst_cycle_count", cycle_count, 0);
    idle_steps(3);

    // Abort wins over start in IDLE.
    track_reset();
    step(1, 1, 0, 8'd3);
    idle_steps(5);
    chk("abort_idle_busy", n_busy, 0);
    chk("abort_idle_done", n_done, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0,
           $urandom_range(0, 255) == 0, TW'($urandom_range(0, 3)));
    end
    idle_steps(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
